// File: rtl/cpu_pkg.sv
// +--------------------------------------------------------------+
// | cpu_pkg : shared divider FSM encodings and counter sizing    |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ZERO = 2'd2
  } div_state_t;

  // One extra bit so the counter can hold DATA_WIDTH itself without wrapping.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int DIV_CNT_W = $clog2(32) + 1;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// +--------------------------------------------------------------+
// | div_step : one combinational restoring shift-subtract step   |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
`default_nettype none

module div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem_in,
  input  logic [DATA_WIDTH-1:0] quo_in,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_out,
  output logic [DATA_WIDTH-1:0] quo_out
);

  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] sub;
  logic                fits;
  logic                unused_sub_msb;

  // Partial remainder stays below the divisor, so only the shifted value needs the extra bit.
  assign shifted        = {rem_in, quo_in[DATA_WIDTH-1]};
  assign fits           = shifted >= {1'b0, divisor};
  assign sub            = shifted - {1'b0, divisor};
  assign unused_sub_msb = sub[DATA_WIDTH];

  assign rem_out = fits ? sub[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
  assign quo_out = {quo_in[DATA_WIDTH-2:0], fits};

endmodule

`default_nettype wire

// File: rtl/div_unit.sv
// +--------------------------------------------------------------+
// | div_unit : iterative restoring divider, DATA_WIDTH cycles/op  |
// | Optional signed support via macro DIV_SIGNED_EN. Rev 1.0     |
// +--------------------------------------------------------------+
`default_nettype none

module div_unit
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sign,
  input  logic                  cancel,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quot,
  output logic [DATA_WIDTH-1:0] rem
);

  localparam int             CW   = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(DATA_WIDTH - 1);

  div_state_t            state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] qsh;
  logic [DATA_WIDTH-1:0] dvs;
  logic [DATA_WIDTH-1:0] step_rem;
  logic [DATA_WIDTH-1:0] step_quo;
  logic [DATA_WIDTH-1:0] a_in;
  logic [DATA_WIDTH-1:0] b_in;
  logic [DATA_WIDTH-1:0] fin_quot;
  logic [DATA_WIDTH-1:0] fin_rem;
  logic                  accept;

  assign accept = (state == ST_IDLE) && start && !cancel;

`ifdef DIV_SIGNED_EN
  logic a_neg;
  logic b_neg;
  logic neg_q;
  logic neg_r;

  assign a_neg    = sign & a[DATA_WIDTH-1];
  assign b_neg    = sign & b[DATA_WIDTH-1];
  assign a_in     = a_neg ? -a : a;
  assign b_in     = b_neg ? -b : b;
  // MIN/-1 falls out naturally: |MIN| is MIN as unsigned and the signs cancel.
  assign fin_quot = neg_q ? -step_quo : step_quo;
  assign fin_rem  = neg_r ? -step_rem : step_rem;

  always_ff @(posedge clk) begin
    if (!rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
    end
  end
`else
  logic unused_sign;

  assign unused_sign = sign;
  assign a_in        = a;
  assign b_in        = b;
  assign fin_quot    = step_quo;
  assign fin_rem     = step_rem;
`endif

  div_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_step (
    .rem_in  (acc),
    .quo_in  (qsh),
    .divisor (dvs),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      acc   <= '0;
      qsh   <= '0;
      dvs   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      quot  <= '0;
      rem   <= '0;
    end else begin
      done <= 1'b0;
      if (cancel) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              // A zero divisor keeps the raw dividend, since it becomes rem untouched.
              qsh   <= (b == '0) ? a : a_in;
              dvs   <= b_in;
              acc   <= '0;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= (b == '0) ? ST_ZERO : ST_BUSY;
            end
          end
          ST_BUSY: begin
            acc <= step_rem;
            qsh <= step_quo;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              quot  <= fin_quot;
              rem   <= fin_rem;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
          ST_ZERO: begin
            quot  <= '1;
            rem   <= qsh;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// +--------------------------------------------------------------+
// | tb_div_unit : directed + randomized bench for div_unit       |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
`default_nettype none

module tb_div_unit;

  localparam int W = 32;

  logic         clk    = 1'b0;
  logic         rst    = 1'b0;
  logic         start  = 1'b0;
  logic         sign   = 1'b0;
  logic         cancel = 1'b0;
  logic [W-1:0] a      = '0;
  logic [W-1:0] b      = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quot;
  logic [W-1:0] rem;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_unit #(
    .DATA_WIDTH (W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sign   (sign),
    .cancel (cancel),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .quot   (quot),
    .rem    (rem)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division rules, signed only when the feature is built in.
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                output logic [W-1:0] q, output logic [W-1:0] r);
    logic sg;
    int   sx;
    int   sy;
`ifdef DIV_SIGNED_EN
    sg = s;
`else
    sg = 1'b0;
    if (s) sg = 1'b0;
`endif
    if (y == '0) begin
      q = '1;
      r = x;
    end else if (!sg) begin
      q = x / y;
      r = x % y;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      q = x;
      r = '0;
    end else begin
      sx = $signed(x);
      sy = $signed(y);
      q  = W'(sx / sy);
      r  = W'(sx % sy);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic watch_no_done(input string tag, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      tick();
      if (done) seen++;
    end
    check(tag, seen, 0);
  endtask

  // Issue one op and wait for done; returns in the done cycle so a caller may chain.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                        input bit junk, input string tag);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    int           cyc;
    int           busy_n;
    int           lat;
    bit           got;
    model(x, y, s, eq, er);
    lat   = (y == '0) ? 1 : W;
    a     = x;
    b     = y;
    sign  = s;
    start = 1'b1;
    tick();
    start  = junk;
    a      = $urandom;
    b      = $urandom;
    sign   = 1'($urandom);
    cyc    = 0;
    busy_n = busy ? 1 : 0;
    got    = 1'b0;
    while (!got && cyc < 3 * W) begin
      tick();
      start = 1'b0;
      cyc++;
      if (done) got = 1'b1;
      if (busy) busy_n++;
    end
    check({tag, "_latency"}, cyc, lat);
    check({tag, "_busy_cycles"}, busy_n, lat);
    check({tag, "_quot"}, quot, eq);
    check({tag, "_rem"}, rem, er);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    repeat (3) tick();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_quot", quot, 0);
    check("reset_rem", rem, 0);
    rst = 1'b1;
    tick();

    run_op(32'd100, 32'd7, 1'b0, 1'b0, "u100_7");
    tick();
    check("done_pulse_width", done, 0);
    check("hold_quot", quot, 32'd14);

    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, "s_m7_2");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, "s_min_m1");
    run_op(32'd5, 32'd0, 1'b0, 1'b1, "div_zero");
    tick();

    // Cancel mid-flight: result registers keep the previous 100/7 answer.
    run_op(32'd100, 32'd7, 1'b0, 1'b0, "pre_cancel");
    tick();
    a = 32'd1000; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel_busy", busy, 0);
    watch_no_done("cancel_no_done", 40);
    check("cancel_keep_quot", quot, 32'd14);
    check("cancel_keep_rem", rem, 32'd2);
    run_op(32'd9, 32'd3, 1'b0, 1'b0, "after_cancel");
    tick();

    start = 1'b1; cancel = 1'b1; a = 32'd50; b = 32'd5;
    tick();
    start = 1'b0; cancel = 1'b0;
    check("start_cancel_busy", busy, 0);
    watch_no_done("start_cancel_no_done", 40);

    a = 32'd1000; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    check("midreset_quot", quot, 0);
    check("midreset_rem", rem, 0);
    watch_no_done("midreset_no_done", 40);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        3:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      run_op(ra, rb, 1'($urandom), 1'($urandom), $sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 0) tick();
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
